// File: rtl/frog_game_sequencer_if.sv
// Game-controller bundle: frog controller status in, frog reset / car step / display counters out.
// The sequencer takes the master modport; the frog controller, lanes and display take the slave side.
interface frog_game_sequencer_if;
   logic       start_btn;
   logic       collision_detected;
   logic       frog_at_top;
   logic       reset_frog;
   logic       car_step;
   logic [1:0] lives;
   logic [3:0] level;
   logic [6:0] score;
   logic       game_over;
   logic [2:0] state;

   modport master (
      input  start_btn, collision_detected, frog_at_top,
      output reset_frog, car_step, lives, level, score, game_over, state
   );

   modport slave (
      output start_btn, collision_detected, frog_at_top,
      input  reset_frog, car_step, lives, level, score, game_over, state
   );
endinterface

// File: rtl/frog_game_sequencer.sv
// Frog game controller: play/death/level-up/game-over FSM, lives/level/score and the car step timer.
// Inputs act one edge after sampling; every output is a register or a decode of registers.
module frog_game_sequencer #(
   parameter int unsigned START_LIVES = 3,
   parameter int unsigned MAX_LEVEL   = 9,
   parameter int unsigned BASE_PERIOD = 12_500_000,
   parameter int unsigned PERIOD_STEP = 1_000_000,
   parameter int unsigned MIN_PERIOD  = 2_500_000,
   parameter int unsigned HOLD_CYCLES = 25_000_000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   frog_game_sequencer_if.master       gif
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PLAY      = 3'd1,
      S_DEATH     = 3'd2,
      S_LEVEL_UP  = 3'd3,
      S_GAME_OVER = 3'd4
   } state_t;

   localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
   localparam logic [3:0]  LEVEL_MAX  = 4'(MAX_LEVEL);
   localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
   // Largest reduction that still leaves the period above the floor.
   localparam logic [31:0] HEADROOM   = (BASE_PERIOD > MIN_PERIOD) ? 32'(BASE_PERIOD - MIN_PERIOD) : 32'd0;

   state_t      state_q, state_d;
   logic        start_q;
   logic [1:0]  lives_q, lives_d;
   logic [3:0]  level_q, level_d;
   logic [6:0]  score_q, score_d;
   logic [23:0] step_q, step_d;
   logic [31:0] hold_q, hold_d;

   logic        start_edge;
   logic [31:0] reduction;
   logic [31:0] period;
   logic        step_end;
   logic        hold_end;

   assign start_edge = gif.start_btn & ~start_q;
   assign reduction  = 32'(level_q) * 32'(PERIOD_STEP);
   assign period     = (reduction >= HEADROOM) ? 32'(MIN_PERIOD) : 32'(BASE_PERIOD) - reduction;
   assign step_end   = ({8'd0, step_q} == (period - 32'd1));
   assign hold_end   = (hold_q == HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         lives_q <= LIVES_INIT;
         level_q <= 4'd0;
         score_q <= 7'd0;
         step_q  <= 24'd0;
         hold_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         start_q <= gif.start_btn;
         lives_q <= lives_d;
         level_q <= level_d;
         score_q <= score_d;
         step_q  <= step_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      level_d = level_q;
      score_d = score_q;
      step_d  = step_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (start_edge) begin
               state_d = S_PLAY;
               lives_d = LIVES_INIT;
               level_d = 4'd0;
               score_d = 7'd0;
               step_d  = 24'd0;
            end
         end
         S_PLAY: begin
            step_d = step_end ? 24'd0 : step_q + 24'd1;
            // Collision wins over a simultaneous crossing.
            if (gif.collision_detected) begin
               state_d = S_DEATH;
               if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            end else if (gif.frog_at_top) begin
               state_d = S_LEVEL_UP;
               if (score_q < 7'd99)     score_d = score_q + 7'd1;
               if (level_q < LEVEL_MAX) level_d = level_q + 4'd1;
            end
         end
         S_DEATH, S_LEVEL_UP: begin
            if (hold_end) begin
               hold_d  = 32'd0;
               step_d  = 24'd0;
               state_d = (state_q == S_DEATH && lives_q == 2'd0) ? S_GAME_OVER : S_PLAY;
            end else begin
               hold_d = hold_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign gif.reset_frog = (state_q != S_PLAY);
   assign gif.car_step   = (state_q == S_PLAY) && step_end;
   assign gif.game_over  = (state_q == S_GAME_OVER);
   assign gif.lives      = lives_q;
   assign gif.level      = level_q;
   assign gif.score      = score_q;
   assign gif.state      = state_q;

endmodule

// File: tb/tb_frog_game_sequencer.sv
// Bench for frog_game_sequencer: directed scenarios plus random play against a game-rule model.
module tb_frog_game_sequencer;
   localparam int BASE  = 10;
   localparam int PSTEP = 2;
   localparam int MINP  = 4;
   localparam int HOLD  = 5;
   localparam int LIVES = 3;
   localparam int MAXL  = 9;

   localparam int ST_IDLE = 0, ST_PLAY = 1, ST_DEATH = 2, ST_LUP = 3, ST_GO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   // Model of the game in terms of its rules, not its registers.
   int m_state, m_lives, m_level, m_score, m_play, m_hold_left;
   bit m_prev;

   frog_game_sequencer_if gif();

   frog_game_sequencer #(
      .START_LIVES(LIVES), .MAX_LEVEL(MAXL), .BASE_PERIOD(BASE),
      .PERIOD_STEP(PSTEP), .MIN_PERIOD(MINP), .HOLD_CYCLES(HOLD)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .gif(gif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int period_of(input int lvl);
      int p;
      p = BASE - lvl * PSTEP;
      return (p < MINP) ? MINP : p;
   endfunction

   task automatic model_reset();
      m_state = ST_IDLE; m_lives = LIVES; m_level = 0; m_score = 0;
      m_play = 0; m_hold_left = 0; m_prev = 1'b0;
   endtask

   task automatic model_step(input bit b, input bit c, input bit t);
      bit start;
      if (!rst_n) begin
         model_reset();
         return;
      end
      start = b && !m_prev;
      m_prev = b;
      case (m_state)
         ST_IDLE, ST_GO: if (start) begin
            m_state = ST_PLAY; m_lives = LIVES; m_level = 0; m_score = 0; m_play = 0;
         end
         ST_PLAY: begin
            if (c) begin
               m_lives = m_lives - 1; m_state = ST_DEATH; m_hold_left = HOLD;
            end else if (t) begin
               m_score = (m_score >= 99) ? 99 : m_score + 1;
               m_level = (m_level >= MAXL) ? MAXL : m_level + 1;
               m_state = ST_LUP; m_hold_left = HOLD;
            end else begin
               m_play++;
            end
         end
         default: begin
            m_hold_left--;
            if (m_hold_left == 0) begin
               m_state = (m_state == ST_DEATH && m_lives == 0) ? ST_GO : ST_PLAY;
               m_play = 0;
            end
         end
      endcase
   endtask

   task automatic check_outputs();
      int p;
      p = period_of(m_level);
      chk("state", int'(gif.state), m_state);
      chk("lives", int'(gif.lives), m_lives);
      chk("level", int'(gif.level), m_level);
      chk("score", int'(gif.score), m_score);
      chk("reset_frog", int'(gif.reset_frog), int'(m_state != ST_PLAY));
      chk("game_over", int'(gif.game_over), int'(m_state == ST_GO));
      chk("car_step", int'(gif.car_step), int'(m_state == ST_PLAY && (m_play % p) == p - 1));
   endtask

   // Drive inputs away from the edge, advance one clock, compare at the falling edge.
   task automatic cycle(input bit b, input bit c, input bit t);
      gif.start_btn = b; gif.collision_detected = c; gif.frog_at_top = t;
      @(posedge clk);
      model_step(b, c, t);
      @(negedge clk);
      cyc++;
      check_outputs();
   endtask

   task automatic wait_state(input int s, input int budget);
      for (int i = 0; i < budget && int'(gif.state) != s; i++) cycle(1'b0, 1'b0, 1'b0);
      chk("wait_state", int'(gif.state), s);
   endtask

   task automatic measure(output int per);
      int first, n;
      first = 0; n = 0; per = 0;
      for (int i = 0; i < 60 && n < 2; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (gif.car_step) begin
            if (n == 0) first = i; else per = i - first;
            n++;
         end
      end
      chk("step_seen", n, 2);
   endtask

   initial begin
      int per, n, k;
      int exp_per [4];
      exp_per = '{8, 6, 4, 4};
      gif.start_btn = 1'b0; gif.collision_detected = 1'b0; gif.frog_at_top = 1'b0;
      model_reset();

      // Reset values while held in reset.
      #12;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0, 0); cycle(0, 0, 0);
      chk("idle_reset_frog", int'(gif.reset_frog), 1);

      // Start with a 3-cycle press: no retrigger while held.
      cycle(1, 0, 0);
      chk("start_play", int'(gif.state), ST_PLAY);
      cycle(1, 0, 0); cycle(1, 0, 0);
      measure(per);
      chk("base_period", per, 10);

      // Single collision: 5 cycles of reset_frog, then a full period to the first step.
      n = 0;
      cycle(0, 1, 0);
      chk("lives_after_hit", int'(gif.lives), 2);
      while (gif.reset_frog && n < 20) begin
         n++;
         cycle(0, 0, 0);
      end
      chk("death_len", n, 5);
      k = 1;
      while (!gif.car_step && k < 40) begin
         cycle(0, 0, 0);
         k++;
      end
      chk("first_step_after_death", k, 10);

      // Two more collisions lead to game over.
      cycle(0, 1, 0);
      wait_state(ST_PLAY, 20);
      cycle(0, 1, 0);
      wait_state(ST_GO, 20);
      chk("go_flag", int'(gif.game_over), 1);
      chk("go_lives", int'(gif.lives), 0);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         cycle(0, 0, 0);
         if (gif.car_step) n++;
      end
      chk("go_no_steps", n, 0);

      // Restart.
      cycle(1, 0, 0);
      chk("restart_state", int'(gif.state), ST_PLAY);
      chk("restart_lives", int'(gif.lives), 3);
      chk("restart_score", int'(gif.score), 0);
      chk("restart_level", int'(gif.level), 0);
      cycle(0, 0, 0);

      // Level progression and the period floor.
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 0, 1);
         wait_state(ST_PLAY, 20);
         chk("prog_score", int'(gif.score), i);
         chk("prog_level", int'(gif.level), i);
         measure(per);
         chk("prog_period", per, exp_per[i-1]);
      end

      // Score saturation after 100+ crossings.
      for (int i = 0; i < 100; i++) begin
         cycle(0, 0, 1);
         wait_state(ST_PLAY, 20);
      end
      chk("score_sat", int'(gif.score), 99);
      chk("level_sat", int'(gif.level), MAXL);

      // Simultaneous collision and crossing.
      cycle(0, 1, 1);
      chk("simul_state", int'(gif.state), ST_DEATH);
      chk("simul_lives", int'(gif.lives), 2);
      chk("simul_score", int'(gif.score), 99);
      chk("simul_level", int'(gif.level), MAXL);

      // Asynchronous reset in the second cycle of the hold.
      cycle(0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_state", int'(gif.state), ST_IDLE);
      chk("async_lives", int'(gif.lives), LIVES);
      chk("async_score", int'(gif.score), 0);
      chk("async_level", int'(gif.level), 0);
      chk("async_reset_frog", int'(gif.reset_frog), 1);
      cycle(0, 0, 0); cycle(0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) cycle(0, 0, 0);
      chk("stay_idle", int'(gif.state), ST_IDLE);

      // Random play, with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_outputs();
            cycle(0, 0, 0);
            rst_n = 1'b1;
         end
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
